// File: rtl/sr_ctrl.sv
// sr_ctrl: architectural status register with a hardware save stack.
// The SR is updated from ALU flags, full-word writes, BIS/BIC masks, interrupt
// entry and RETI. Exactly one update class takes effect per cycle, in this order:
// reti, irq_entry, wr_en, bis/bic, flag_we.
// Optional macro SR_LPM_EXIT_EN adds lpm_exit. When asserted, lpm_exit clears the
// low-power bits in the top stack entry, so the next RETI returns in active mode.
module sr_ctrl #(
  parameter int               WIDTH       = 16,
  parameter int               STACK_DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
  input  logic                             clk,
  input  logic                             rst_n,
`ifdef SR_LPM_EXIT_EN
  input  logic                             lpm_exit,
`endif
  input  logic [3:0]                       flag_we,
  input  logic [3:0]                       cvnz_in,
  input  logic                             wr_en,
  input  logic [WIDTH-1:0]                 wr_data,
  input  logic                             bis_en,
  input  logic                             bic_en,
  input  logic [WIDTH-1:0]                 mask_data,
  input  logic                             irq_entry,
  input  logic                             reti,
  output logic [WIDTH-1:0]                 sr_out,
  output logic                             gie,
  output logic                             cpuoff,
  output logic [$clog2(STACK_DEPTH+1)-1:0] stack_level,
  output logic                             stk_ovf,
  output logic                             stk_unf
);

  localparam int LW = $clog2(STACK_DEPTH + 1);

  // Bits cleared on interrupt entry: C, Z, N, GIE, CPUOFF, OSCOFF, SCG1, V.
  // SCG0 (bit 6) and all bits above V are kept.
  localparam logic [WIDTH-1:0] IRQ_CLR = WIDTH'(9'h1BF);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] stk_q [STACK_DEPTH];
  logic [WIDTH-1:0] stk_d [STACK_DEPTH];

  logic [WIDTH-1:0] top_raw;
  logic [WIDTH-1:0] top_mod;
  logic             lpm_act;
  logic [WIDTH-1:0] mask_tmp;
  logic             empty;
  logic             full;

  assign empty = (level_q == '0);
  assign full  = (level_q == LW'(STACK_DEPTH));

  // Select the current top-of-stack entry; an empty stack yields RESET_VAL.
  always_comb begin
    top_raw = RESET_VAL;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (int'(level_q) == i + 1) top_raw = stk_q[i];
    end
  end

`ifdef SR_LPM_EXIT_EN
  // Low-power exit clears CPUOFF, OSCOFF and SCG1 in the saved context.
  localparam logic [WIDTH-1:0] LPM_CLR = WIDTH'(9'h0B0);

  // Apply the low-power exit to the top entry; the popped value on RETI is the modified one.
  always_comb begin
    lpm_act = lpm_exit && !empty;
    top_mod = lpm_act ? (top_raw & ~LPM_CLR) : top_raw;
  end
`else
  // Without the low-power exit feature the top entry is never modified in place.
  always_comb begin
    lpm_act = 1'b0;
    top_mod = top_raw;
  end
`endif

  // Next-state logic: the highest-priority active class wins.
  always_comb begin
    sr_d     = sr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    stk_d    = stk_q;
    mask_tmp = sr_q;

    if (lpm_act) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        if (int'(level_q) == i + 1) stk_d[i] = top_mod;
      end
    end

    if (reti) begin
      if (!empty) begin
        sr_d    = top_mod;
        level_d = level_q - LW'(1);
      end else begin
        unf_d = 1'b1;
      end
    end else if (irq_entry) begin
      sr_d = sr_q & ~IRQ_CLR;
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
          if (int'(level_q) == i) stk_d[i] = sr_q;
        end
        level_d = level_q + LW'(1);
      end
    end else if (wr_en) begin
      sr_d = wr_data;
    end else if (bis_en || bic_en) begin
      if (bis_en) mask_tmp = mask_tmp | mask_data;
      if (bic_en) mask_tmp = mask_tmp & ~mask_data;
      sr_d = mask_tmp;
    end else begin
      if (flag_we[3]) sr_d[0] = cvnz_in[3];
      if (flag_we[2]) sr_d[8] = cvnz_in[2];
      if (flag_we[1]) sr_d[2] = cvnz_in[1];
      if (flag_we[0]) sr_d[1] = cvnz_in[0];
    end
  end

  // State registers; reset discards all saved context.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q    <= RESET_VAL;
      level_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stk_q[i] <= RESET_VAL;
    end else begin
      sr_q    <= sr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      stk_q   <= stk_d;
    end
  end

  assign sr_out      = sr_q;
  assign gie         = sr_q[3];
  assign cpuoff      = sr_q[4];
  assign stack_level = level_q;
  assign stk_ovf     = ovf_q;
  assign stk_unf     = unf_q;

endmodule

// File: tb/tb_sr_ctrl.sv
`timescale 1ns/1ps
module tb_sr_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  flag_we = '0;
  logic [3:0]  cvnz_in = '0;
  logic        wr_en = 1'b0;
  logic [15:0] wr_data = '0;
  logic        bis_en = 1'b0;
  logic        bic_en = 1'b0;
  logic [15:0] mask_data = '0;
  logic        irq_entry = 1'b0;
  logic        reti = 1'b0;
`ifdef SR_LPM_EXIT_EN
  logic        lpm_exit = 1'b0;
`endif
  logic [15:0] sr_out;
  logic        gie, cpuoff, stk_ovf, stk_unf;
  logic [2:0]  stack_level;

  sr_ctrl #(.WIDTH(16), .STACK_DEPTH(4), .RESET_VAL(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef SR_LPM_EXIT_EN
    .lpm_exit(lpm_exit),
`endif
    .flag_we(flag_we), .cvnz_in(cvnz_in), .wr_en(wr_en), .wr_data(wr_data),
    .bis_en(bis_en), .bic_en(bic_en), .mask_data(mask_data),
    .irq_entry(irq_entry), .reti(reti), .sr_out(sr_out), .gie(gie),
    .cpuoff(cpuoff), .stack_level(stack_level), .stk_ovf(stk_ovf), .stk_unf(stk_unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] sr;
    int          lvl;
    bit          ovf;
    bit          unf;
  } exp_t;

  exp_t        exp_q[$];
  int          n_chk = 0;
  int          n_err = 0;

  // Reference model: SR value, a queue as the save stack, sticky error bits.
  logic [15:0] m_sr;
  logic [15:0] m_stk[$];
  bit          m_ovf, m_unf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sr = 16'h0000;
    m_stk.delete();
    m_ovf = 0;
    m_unf = 0;
  endtask

  // Apply the architectural rules to the inputs currently being driven.
  task automatic model_step();
    logic lpm;
    logic [15:0] t;
    lpm = 1'b0;
`ifdef SR_LPM_EXIT_EN
    lpm = lpm_exit;
`endif
    if (lpm && m_stk.size() > 0)
      m_stk[m_stk.size()-1] = m_stk[m_stk.size()-1] & ~16'h00B0;
    if (reti) begin
      if (m_stk.size() > 0) m_sr = m_stk.pop_back();
      else m_unf = 1;
    end else if (irq_entry) begin
      if (m_stk.size() >= 4) m_ovf = 1;
      else m_stk.push_back(m_sr);
      m_sr = m_sr & ~16'h01BF;
    end else if (wr_en) begin
      m_sr = wr_data;
    end else if (bis_en || bic_en) begin
      t = m_sr;
      if (bis_en) t = t | mask_data;
      if (bic_en) t = t & ~mask_data;
      m_sr = t;
    end else begin
      if (flag_we[3]) m_sr[0] = cvnz_in[3];
      if (flag_we[2]) m_sr[8] = cvnz_in[2];
      if (flag_we[1]) m_sr[2] = cvnz_in[1];
      if (flag_we[0]) m_sr[1] = cvnz_in[0];
    end
  endtask

  task automatic idle();
    flag_we = '0; cvnz_in = '0; wr_en = 0; wr_data = '0;
    bis_en = 0; bic_en = 0; mask_data = '0; irq_entry = 0; reti = 0;
`ifdef SR_LPM_EXIT_EN
    lpm_exit = 0;
`endif
  endtask

  // Present current inputs for one edge; the expected response goes to the scoreboard.
  task automatic tick();
    exp_t e;
    model_step();
    e.sr = m_sr; e.lvl = m_stk.size(); e.ovf = m_ovf; e.unf = m_unf;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Monitor: every edge with a pending expectation is compared against the DUT.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sr_out", 32'(sr_out), 32'(e.sr));
        chk("stack_level", 32'(stack_level), 32'(e.lvl));
        chk("stk_ovf", 32'(stk_ovf), 32'(e.ovf));
        chk("stk_unf", 32'(stk_unf), 32'(e.unf));
        chk("gie", 32'(gie), 32'(e.sr[3]));
        chk("cpuoff", 32'(cpuoff), 32'(e.sr[4]));
      end
    end
  end

  initial begin
    logic [15:0] first_val;
    idle();
    model_reset();
    #2;
    chk("reset_sr", 32'(sr_out), 32'h0);
    chk("reset_level", 32'(stack_level), 32'h0);
    chk("reset_ovf", 32'(stk_ovf), 32'h0);
    chk("reset_unf", 32'(stk_unf), 32'h0);
    #5 rst_n = 1'b1;
    @(posedge clk); #2;

    // Flag updates in {C,V,N,Z} order.
    flag_we = 4'b1111; cvnz_in = 4'b1010; tick();
    chk("flags_all", 32'(sr_out), 32'h0005);
    idle(); flag_we = 4'b0001; cvnz_in = 4'b0001; tick();
    chk("flags_z", 32'(sr_out), 32'h0007);
    idle(); flag_we = 4'b0000; cvnz_in = 4'b0000; tick();
    chk("flags_none", 32'(sr_out), 32'h0007);

    // Full write, interrupt entry, return.
    idle(); wr_en = 1; wr_data = 16'h00F8; tick();
    idle(); irq_entry = 1; tick();
    chk("irq_sr", 32'(sr_out), 32'h0040);
    chk("irq_level", 32'(stack_level), 32'h1);
    idle(); reti = 1; tick();
    chk("reti_sr", 32'(sr_out), 32'h00F8);
    chk("reti_level", 32'(stack_level), 32'h0);

    // Overflow then underflow.
    first_val = 16'h1234;
    idle(); wr_en = 1; wr_data = first_val; tick();
    for (int i = 0; i < 5; i++) begin idle(); irq_entry = 1; tick(); end
    chk("ovf_level", 32'(stack_level), 32'h4);
    chk("ovf_flag", 32'(stk_ovf), 32'h1);
    for (int i = 0; i < 5; i++) begin idle(); reti = 1; tick(); end
    chk("unf_level", 32'(stack_level), 32'h0);
    chk("unf_flag", 32'(stk_unf), 32'h1);
    chk("unf_sr_first", 32'(sr_out), 32'(first_val));

    // BIS and BIC together, flags ignored in the same cycle.
    idle(); wr_en = 1; wr_data = 16'h000F; tick();
    idle(); bis_en = 1; bic_en = 1; mask_data = 16'h0003; flag_we = 4'b1111; cvnz_in = 4'b1111; tick();
    chk("bisbic", 32'(sr_out), 32'h000C);

    // Same-cycle reti and irq_entry at depth 2.
    idle(); wr_en = 1; wr_data = 16'h00AA; tick();
    idle(); irq_entry = 1; tick();
    idle(); wr_en = 1; wr_data = 16'h0055; tick();
    idle(); irq_entry = 1; tick();
    idle(); reti = 1; irq_entry = 1; tick();
    chk("reti_irq_sr", 32'(sr_out), 32'h0055);
    chk("reti_irq_level", 32'(stack_level), 32'h1);

    // Asynchronous reset between edges.
    idle();
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_sr", 32'(sr_out), 32'h0);
    chk("async_level", 32'(stack_level), 32'h0);
    chk("async_unf", 32'(stk_unf), 32'h0);
    chk("async_ovf", 32'(stk_ovf), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #2;

`ifdef SR_LPM_EXIT_EN
    idle(); wr_en = 1; wr_data = 16'h0018; tick();
    idle(); irq_entry = 1; tick();
    idle(); lpm_exit = 1; tick();
    idle(); reti = 1; tick();
    chk("lpm_exit_sr", 32'(sr_out), 32'h0008);
`endif

    // Randomized traffic with overlapping requests.
    for (int i = 0; i < 400; i++) begin
      idle();
      flag_we   = 4'($urandom);
      cvnz_in   = 4'($urandom);
      wr_data   = 16'($urandom);
      mask_data = 16'($urandom);
      reti      = ($urandom_range(0, 7) == 0);
      irq_entry = ($urandom_range(0, 5) == 0);
      wr_en     = ($urandom_range(0, 7) == 0);
      bis_en    = ($urandom_range(0, 3) == 0);
      bic_en    = ($urandom_range(0, 3) == 0);
`ifdef SR_LPM_EXIT_EN
      lpm_exit  = ($urandom_range(0, 4) == 0);
`endif
      tick();
    end
    idle();

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
